// File: rtl/priority_encoder_sv_if.sv
// Request/result bundle for priority_encoder_sv: request bits in, combinational
// and registered encoder results out.
interface priority_encoder_sv_if #(
  parameter int WIDTH = 3,
  parameter int OUT_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0] in_i;
  logic [OUT_W-1:0] out_o;
  logic             valid_o;
  logic             multi_o;
  logic [OUT_W-1:0] out_q_o;
  logic             valid_q_o;
  logic             change_o;

  modport master (
    output in_i,
    input  out_o, valid_o, multi_o, out_q_o, valid_q_o, change_o
  );

  modport slave (
    input  in_i,
    output out_o, valid_o, multi_o, out_q_o, valid_q_o, change_o
  );
endinterface

// File: rtl/priority_encoder_sv.sv
// Priority encoder: the highest set request bit wins. The combinational index,
// valid and multi outputs are paired with a registered copy and a change pulse.
module priority_encoder_sv #(
  parameter int WIDTH = 3,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_sv_if.slave  bus
);

  // Two or more bits are set exactly when clearing the lowest set bit leaves a
  // nonzero value.
  function automatic logic has_multi(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] lowered;
    lowered = v & (v - {{(WIDTH-1){1'b0}}, 1'b1});
    return |lowered;
  endfunction

  logic [OUT_W-1:0] out_s;
  logic             valid_s;
  logic             multi_s;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;

  // Ascending scan so that the last (highest) set bit overrides lower ones.
  always_comb begin
    out_s = {OUT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_i[i]) begin
        out_s = OUT_W'(i);
      end else begin
        out_s = out_s;
      end
    end
    valid_s = |bus.in_i;
    multi_s = has_multi(bus.in_i);
  end

  // Next-state values for the capture registers and the change pulse.
  always_comb begin
    out_d    = out_s;
    valid_d  = valid_s;
    change_d = ({valid_s, out_s} != {valid_q, out_q});
  end

  // Capture registers; reset clears them to the {0, 0} idle code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= {OUT_W{1'b0}};
      valid_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      valid_q  <= valid_d;
      change_q <= change_d;
    end
  end

  assign bus.out_o     = out_s;
  assign bus.valid_o   = valid_s;
  assign bus.multi_o   = multi_s;
  assign bus.out_q_o   = out_q;
  assign bus.valid_q_o = valid_q;
  assign bus.change_o  = change_q;

endmodule

// File: tb/tb_priority_encoder_sv.sv
// Directed bench for priority_encoder_sv at WIDTH=3 with hand-computed results.
module tb_priority_encoder_sv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  priority_encoder_sv_if #(.WIDTH(3), .OUT_W(2)) bus_if ();

  priority_encoder_sv #(.WIDTH(3), .OUT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus_if.valid_q_o, bus_if.out_q_o, bus_if.change_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_regs: got v=%b o=%b c=%b, want v=0 o=00 c=0",
               bus_if.valid_q_o, bus_if.out_q_o, bus_if.change_o);
    end
  endtask

  // All eight codes checked with rst held, so reset must not touch the comb path.
  task automatic test_comb_codes();
    logic [2:0] codes    [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [1:0] exp_out  [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    logic       exp_val  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_mul  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      bus_if.in_i = codes[k];
      #1;
      n_cmp++;
      if ({bus_if.out_o, bus_if.valid_o} !== {exp_out[k], exp_val[k]}) begin
        n_bad++;
        $display("FAIL comb_encode in=%b: got out=%b valid=%b, want out=%b valid=%b",
                 codes[k], bus_if.out_o, bus_if.valid_o, exp_out[k], exp_val[k]);
      end
      n_cmp++;
      if (bus_if.multi_o !== exp_mul[k]) begin
        n_bad++;
        $display("FAIL comb_multi in=%b: got %b, want %b", codes[k], bus_if.multi_o, exp_mul[k]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus_if.in_i = 3'b000;
    rst = 1'b0;
    edge_settle();
    n_cmp++;
    if (bus_if.change_o !== 1'b0) begin
      n_bad++;
      $display("FAIL release_zero_change: got %b, want 0", bus_if.change_o);
    end
    @(negedge clk);
    bus_if.in_i = 3'b100;
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o} !== 4'b1011) begin
      n_bad++;
      $display("FAIL latency_capture: got o=%b v=%b c=%b, want o=10 v=1 c=1",
               bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o);
    end
    edge_settle();
    n_cmp++;
    if (bus_if.change_o !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_hold_change: got %b, want 0", bus_if.change_o);
    end
  endtask

  task automatic test_valid_drop();
    @(negedge clk);
    bus_if.in_i = 3'b001;
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o} !== 4'b0011) begin
      n_bad++;
      $display("FAIL drop_first: got o=%b v=%b c=%b, want o=00 v=1 c=1",
               bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o);
    end
    @(negedge clk);
    bus_if.in_i = 3'b000;
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o} !== 4'b0001) begin
      n_bad++;
      $display("FAIL drop_valid: got o=%b v=%b c=%b, want o=00 v=0 c=1",
               bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o);
    end
  endtask

  // Held {valid,out} must not pulse change even when multi flips (010 -> 011).
  task automatic test_back_to_back();
    logic [2:0] seq    [4] = '{3'b010, 3'b010, 3'b011, 3'b111};
    logic       exp_ch [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_oq [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_if.in_i = seq[k];
      edge_settle();
      n_cmp++;
      if ({bus_if.out_q_o, bus_if.change_o} !== {exp_oq[k], exp_ch[k]}) begin
        n_bad++;
        $display("FAIL b2b step%0d in=%b: got o=%b c=%b, want o=%b c=%b",
                 k, seq[k], bus_if.out_q_o, bus_if.change_o, exp_oq[k], exp_ch[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus_if.in_i = 3'b100;
    edge_settle();
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL async_pre: got o=%b v=%b, want o=10 v=1", bus_if.out_q_o, bus_if.valid_q_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_clear: got o=%b v=%b c=%b, want o=00 v=0 c=0",
               bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o);
    end
    n_cmp++;
    if ({bus_if.out_o, bus_if.valid_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL async_comb_hold: got out=%b valid=%b, want out=10 valid=1",
               bus_if.out_o, bus_if.valid_o);
    end
    bus_if.in_i = 3'b011;
    #1;
    n_cmp++;
    if ({bus_if.out_o, bus_if.multi_o} !== 3'b011) begin
      n_bad++;
      $display("FAIL async_comb_track: got out=%b multi=%b, want out=01 multi=1",
               bus_if.out_o, bus_if.multi_o);
    end
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_edge_held: got o=%b v=%b, want o=00 v=0", bus_if.out_q_o, bus_if.valid_q_o);
    end
  endtask

  task automatic test_release_nonzero();
    @(negedge clk);
    bus_if.in_i = 3'b010;
    rst = 1'b0;
    edge_settle();
    n_cmp++;
    if ({bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o} !== 4'b0111) begin
      n_bad++;
      $display("FAIL release_nonzero: got o=%b v=%b c=%b, want o=01 v=1 c=1",
               bus_if.out_q_o, bus_if.valid_q_o, bus_if.change_o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.in_i = 3'b000;
    test_reset();
    test_comb_codes();
    test_latency();
    test_valid_drop();
    test_back_to_back();
    test_async_reset();
    test_release_nonzero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
